// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_pkg : shared widths and FSM encoding for the AES stream wrapper  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package aes_pkg;

  localparam int WORDS_PER_BLOCK = 4;
  localparam int AES_WORD_W      = 32;
  localparam int AES_BLOCK_W     = WORDS_PER_BLOCK * AES_WORD_W;

  typedef enum logic [2:0] {
    ST_LOAD_KEY  = 3'd0,
    ST_LOAD_DATA = 3'd1,
    ST_START     = 3'd2,
    ST_BUSY      = 3'd3,
    ST_DRAIN     = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/aes_word_ser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_word_ser : 128->32 load/shift serializer with valid/ready/last   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module aes_word_ser
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [AES_BLOCK_W-1:0] load_data,
  output logic [AES_WORD_W-1:0]  data,
  output logic                   valid,
  input  logic                   ready,
  output logic                   last,
  output logic                   done
);

  logic [AES_BLOCK_W-1:0] r_shift;
  logic [1:0]             r_cnt;
  logic                   r_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= 2'd0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_shift <= load_data;
      r_cnt   <= 2'd0;
      r_valid <= 1'b1;
    end else if (r_valid && ready) begin
      // Most significant word leaves first; zeros backfill.
      r_shift <= {r_shift[AES_BLOCK_W-AES_WORD_W-1:0], {AES_WORD_W{1'b0}}};
      r_cnt   <= r_cnt + 2'd1;
      if (r_cnt == 2'd3) r_valid <= 1'b0;
    end
  end

  assign data  = r_shift[AES_BLOCK_W-1 -: AES_WORD_W];
  assign valid = r_valid;
  assign last  = r_valid && (r_cnt == 2'd3);
  assign done  = r_valid && ready && (r_cnt == 2'd3);

endmodule
`default_nettype wire

// File: rtl/aes_stream_wrapper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_stream_wrapper : word-serial key/plaintext loader and ciphertext |
// | drain around the iterative AES-128 core.          Rev 1.0            |
// +----------------------------------------------------------------------+
module aes_stream_wrapper
  import aes_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int W       = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_key_reuse,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_last,
  output logic         core_start,
  output logic [127:0] core_key,
  output logic [127:0] core_data,
  input  logic         core_ready,
  input  logic [127:0] core_dout,
  output logic         key_valid,
  output logic         err
);

  localparam int TCW = $clog2(TIMEOUT);
  localparam logic [TCW-1:0] C_TLIMIT = TCW'(TIMEOUT - 1);

  state_t         r_state;
  state_t         w_next;
  logic [1:0]     r_wcnt;
  logic [TCW-1:0] r_tcnt;
  logic           r_seen_busy;
  logic           r_s_ready;
  logic           r_core_start;
  logic           r_key_valid;
  logic           r_err;
  logic [127:0]   r_core_key;
  logic [127:0]   r_core_data;

  logic w_beat;
  logic w_last_beat;
  logic w_timeout;
  logic w_capture;
  logic w_drain_done;
  logic w_keep_key;

  assign w_beat      = s_valid && r_s_ready;
  assign w_last_beat = w_beat && (r_wcnt == 2'd3);
  assign w_timeout   = (r_state == ST_START) && core_ready && (r_tcnt == C_TLIMIT);
  assign w_keep_key  = cfg_key_reuse && r_key_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_LOAD_KEY;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      ST_LOAD_KEY:  if (w_last_beat) w_next = ST_LOAD_DATA;
      ST_LOAD_DATA: if (w_last_beat) w_next = ST_START;
      ST_START: begin
        if (!core_ready)                w_next = ST_BUSY;
        else if (r_tcnt == C_TLIMIT)    w_next = ST_LOAD_KEY;
      end
      ST_BUSY: begin
        if (core_ready && r_seen_busy) begin
          w_capture = 1'b1;
          w_next    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_drain_done) w_next = w_keep_key ? ST_LOAD_DATA : ST_LOAD_KEY;
      end
      default: w_next = ST_LOAD_KEY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wcnt       <= 2'd0;
      r_tcnt       <= '0;
      r_seen_busy  <= 1'b0;
      r_s_ready    <= 1'b0;
      r_core_start <= 1'b0;
      r_key_valid  <= 1'b0;
      r_err        <= 1'b0;
      r_core_key   <= '0;
      r_core_data  <= '0;
    end else begin
      // Registered from the next state so the handshake lines never glitch.
      r_s_ready    <= (w_next == ST_LOAD_KEY) || (w_next == ST_LOAD_DATA);
      r_core_start <= (w_next == ST_START);
      r_tcnt       <= (r_state == ST_START) ? r_tcnt + TCW'(1) : '0;

      if (w_beat) r_wcnt <= r_wcnt + 2'd1;
      if (w_beat && r_state == ST_LOAD_KEY)  r_core_key  <= {r_core_key[95:0], s_data};
      if (w_beat && r_state == ST_LOAD_DATA) r_core_data <= {r_core_data[95:0], s_data};

      if (r_state == ST_LOAD_KEY && w_last_beat)             r_key_valid <= 1'b1;
      else if (w_timeout || (w_drain_done && !w_keep_key))   r_key_valid <= 1'b0;

      if (w_timeout) r_err <= 1'b1;

      if (r_state == ST_START && !core_ready) r_seen_busy <= 1'b1;
      else if (w_capture)                     r_seen_busy <= 1'b0;
    end
  end

  aes_word_ser u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_capture),
    .load_data (core_dout),
    .data      (m_data),
    .valid     (m_valid),
    .ready     (m_ready),
    .last      (m_last),
    .done      (w_drain_done)
  );

  assign s_ready    = r_s_ready;
  assign core_start = r_core_start;
  assign core_key   = r_core_key;
  assign core_data  = r_core_data;
  assign key_valid  = r_key_valid;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_stream_wrapper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_aes_stream_wrapper : self-checking bench with a behavioural core  |
// | stub and a word-level scoreboard.                 Rev 1.0            |
// +----------------------------------------------------------------------+
module tb_aes_stream_wrapper;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_key_reuse = 1'b0;
  logic [31:0]  s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [31:0]  m_data;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic         m_last;
  logic         core_start;
  logic [127:0] core_key;
  logic [127:0] core_data;
  logic         core_ready;
  logic [127:0] core_dout;
  logic         key_valid;
  logic         err;

  int checks = 0;
  int errors = 0;

  aes_stream_wrapper #(.TIMEOUT(16), .W(32)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_key_reuse(cfg_key_reuse),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .core_start(core_start), .core_key(core_key), .core_data(core_data),
    .core_ready(core_ready), .core_dout(core_dout),
    .key_valid(key_valid), .err(err)
  );

  always #5 clk = ~clk;

  // Reference cipher: the real FIPS-197 vector, otherwise an arbitrary keyed mix.
  function automatic logic [127:0] ref_cipher(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return {k[63:0], k[127:64]} ^ p ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Core stub: two-stage start edge detect, random busy time, then result.
  logic stub_stuck = 1'b0;
  logic st_s1, st_s2, stub_busy;
  int   stub_cnt;
  logic [127:0] stub_dout;

  always @(posedge clk) begin
    if (!rst_n) begin
      st_s1 <= 1'b0; st_s2 <= 1'b0; stub_busy <= 1'b0; stub_cnt <= 0; stub_dout <= '0;
    end else begin
      st_s1 <= core_start;
      st_s2 <= st_s1;
      if (stub_busy) begin
        if (stub_cnt <= 1) begin
          stub_busy <= 1'b0;
          stub_dout <= ref_cipher(core_key, core_data);
        end else stub_cnt <= stub_cnt - 1;
      end else if (st_s1 && !st_s2 && !stub_stuck) begin
        stub_busy <= 1'b1;
        stub_cnt  <= int'($urandom_range(3, 10));
      end
    end
  end
  assign core_ready = stub_stuck | !stub_busy;
  assign core_dout  = stub_dout;

  // Downstream ready: 0 = always ready, 1 = random, 2 = driven by the sequence.
  int mr_mode = 0;
  always @(posedge clk) begin
    #1;
    if (mr_mode == 0)      m_ready = 1'b1;
    else if (mr_mode == 1) m_ready = 1'($urandom_range(0, 1));
  end

  // Output scoreboard and hold-stability monitor.
  logic [31:0] exp_q[$];
  int          out_idx = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      out_idx    = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 128'(m_valid), 128'(1));
        chk("hold_data", 128'(m_data), 128'(prev_data));
        chk("hold_last", 128'(m_last), 128'(prev_last));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", 128'(m_data), 128'hx);
        else begin
          chk("m_data", 128'(m_data), 128'(exp_q.pop_front()));
          chk("m_last", 128'(m_last), 128'(out_idx == 3));
          out_idx = (out_idx + 1) % 4;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic send_word(input logic [31:0] w, input bit gap);
    int t = 0;
    s_data  = w;
    s_valid = 1'b1;
    while (!s_ready && t < 64) begin @(posedge clk); #1; t++; end
    if (t >= 64) chk("s_ready_wait", 128'(s_ready), 128'(1));
    @(posedge clk); #1;
    s_valid = 1'b0;
    if (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_block(input logic [127:0] b, input bit gap);
    for (int i = 0; i < 4; i++) send_word(b[127-32*i -: 32], gap);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin @(posedge clk); #1; t++; end
    if (t >= 400) chk("drain_wait", 128'(exp_q.size()), 128'(0));
    chk("s_ready_after_drain", 128'(s_ready), 128'(1));
  endtask

  // Model of the held key.
  bit           key_held = 1'b0;
  logic [127:0] held_key;

  task automatic run_job(input logic [127:0] key, input logic [127:0] pt, input bit reuse,
                         input bit gap, input logic [127:0] exp_ct);
    logic [127:0] k_eff;
    cfg_key_reuse = reuse;
    chk("key_valid_pre", 128'(key_valid), 128'(key_held));
    if (key_held) k_eff = held_key;
    else begin
      send_block(key, gap);
      k_eff = key;
    end
    send_block(pt, gap);
    chk("start_after_last_beat", 128'({s_ready, core_start}), 128'(2'b01));
    chk("core_key", core_key, k_eff);
    chk("core_data", core_data, pt);
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_ct[127-32*i -: 32]);
    held_key = k_eff;
    wait_drain();
    key_held = reuse;
    chk("key_valid_post", 128'(key_valid), 128'(key_held));
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    bit           reuse;
    bit           gap;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [127:0] k, p, ke;
    bit r, g;
    int n;

    vecs[0] = '{FIPS_KEY, FIPS_PT, 1'b1, 1'b0, FIPS_CT};
    vecs[1] = '{FIPS_KEY, 128'hdeadbeef_01234567_89abcdef_fedcba98, 1'b0, 1'b0,
                ref_cipher(FIPS_KEY, 128'hdeadbeef_01234567_89abcdef_fedcba98)};
    vecs[2] = '{128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'h3243f6a8_885a308d_313198a2_e0370734,
                1'b1, 1'b1, ref_cipher(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
                                       128'h3243f6a8_885a308d_313198a2_e0370734)};
    vecs[3] = '{128'h0, 128'hffffffff_00000000_ffffffff_00000000, 1'b1, 1'b0,
                ref_cipher(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
                           128'hffffffff_00000000_ffffffff_00000000)};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {s_ready, m_valid, core_start, key_valid, err, m_last, m_data},
        128'(0));
    chk("reset_core_regs", core_key | core_data, 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors (vec 3 reuses the key held after vec 2)
    for (int i = 0; i < 4; i++) run_job(vecs[i].key, vecs[i].pt, vecs[i].reuse, vecs[i].gap, vecs[i].ct);

    // Randomized jobs with random downstream backpressure
    mr_mode = 1;
    for (int j = 0; j < 12; j++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      r = 1'($urandom_range(0, 1));
      g = 1'($urandom_range(0, 1));
      ke = key_held ? held_key : k;
      run_job(k, p, r, g, ref_cipher(ke, p));
    end
    mr_mode = 0;
    @(posedge clk); #1;

    // Five-cycle stall in the middle of DRAIN
    mr_mode = 2;
    m_ready = 1'b1;
    k = 128'h11112222_33334444_55556666_77778888;
    p = 128'h99990000_aaaabbbb_ccccdddd_eeeeffff;
    cfg_key_reuse = 1'b0;
    ke = key_held ? held_key : k;
    if (!key_held) send_block(k, 1'b0);
    send_block(p, 1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(ref_cipher(ke, p)[127-32*i -: 32]);
    n = 0;
    while (exp_q.size() > 2 && n < 100) begin @(posedge clk); #1; n++; end
    m_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("stall_no_loss", 128'(exp_q.size()), 128'(2));
    m_ready = 1'b1;
    wait_drain();
    key_held = 1'b0;
    mr_mode = 0;

    // Reset pulsed while the core is busy, then a fresh job
    send_block(k, 1'b0);
    send_block(p, 1'b0);
    n = 0;
    while (core_start && n < 50) begin @(posedge clk); #1; n++; end
    chk("entered_busy", 128'({core_start, core_ready}), 128'(2'b00));
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("busy_reset_outputs", {s_ready, m_valid, core_start, key_valid, err, m_last, m_data},
        128'(0));
    chk("busy_reset_core_regs", core_key | core_data, 128'(0));
    rst_n = 1'b1;
    exp_q.delete();
    key_held = 1'b0;
    @(posedge clk); #1;
    run_job(FIPS_KEY, FIPS_PT, 1'b0, 1'b0, FIPS_CT);

    // Start timeout: core ready never falls
    stub_stuck = 1'b1;
    send_block(k, 1'b0);
    send_block(p, 1'b0);
    chk("timeout_start_high", 128'(core_start), 128'(1));
    n = 0;
    while (!err && n < 40) begin @(posedge clk); #1; n++; end
    chk("timeout_cycles", 128'(n), 128'(16));
    chk("timeout_state", 128'({err, core_start, key_valid, s_ready}), 128'(4'b1001));
    stub_stuck = 1'b0;
    key_held = 1'b0;
    @(posedge clk); #1;
    run_job(k, p, 1'b0, 1'b0, ref_cipher(k, p));
    chk("err_sticky", 128'(err), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/aes_stream_wrapper.md
Name: aes_stream_wrapper

Overview:
- Word-serial front/back end for the iterative AES-128 core.
- Upstream side: assembles 32-bit input words into the 128-bit key and plaintext, then issues the core's level-sensitive start.
- Waits out the core's busy window, captures the ciphertext, and returns it as four 32-bit words.
- Sits directly between the system bus adapter and the core instance.

Parameters:
- TIMEOUT, 16, max cycles from start assertion to the core's ready falling before an error is flagged; must be ≥ 3.
- W, 32, stream word width; fixed at 32, 128/W = 4 words per block.

Ports:
- clk  in  1  single clock
- rst_n  in  1  synchronous active-low reset
- cfg_key_reuse  in  1  1 = skip key words when a key is already held
- s_data  in  32  input word
- s_valid  in  1  input word valid
- s_ready  out  1  wrapper accepts word
- m_data  out  32  ciphertext word
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts word
- m_last  out  1  marks 4th output word
- core_start  out  1  to core start
- core_key  out  128  to core keyIn, registered
- core_data  out  128  to core data_in, registered
- core_ready  in  1  from core ready
- core_dout  in  128  from core data_out
- key_valid  out  1  a complete key is held
- err  out  1  sticky start-timeout error

Behaviour:
- Reset (rst_n low at a clk edge):
  - All outputs 0, including s_ready, m_valid, core_start, key_valid, err, core_key, core_data.
  - FSM returns to LOAD_KEY; word counter, timeout counter and the "seen busy" flag are cleared.
  - Reset mid-operation abandons the block; no partial output is emitted.
- Word order: big-endian. The first word accepted fills [127:96], the fourth fills [31:0]. The same order applies on output.
- Handshake: a transfer occurs on any edge where valid && ready. m_data, m_valid and m_last stay stable while m_valid && !m_ready.
- States:
  - LOAD_KEY: s_ready = 1. Four beats go into core_key. On the 4th beat, key_valid <= 1 and the FSM goes to LOAD_DATA.
  - LOAD_DATA: s_ready = 1. Four beats go into core_data. On the 4th beat, go to START.
  - START:
    - core_start = 1 (registered). The timeout counter increments each cycle.
    - When core_ready is sampled 0, core_start <= 0 and the FSM goes to BUSY. Holding start until busy guarantees the core's two-stage edge detector sees the rising edge.
    - If the counter reaches TIMEOUT first: err <= 1, core_start <= 0, key_valid <= 0, FSM goes to LOAD_KEY.
  - BUSY: s_ready = 0. Wait for core_ready sampled 1. On that edge capture core_dout into the output shift register and go to DRAIN. No timeout applies in BUSY.
  - DRAIN:
    - m_valid = 1. Each accepted beat shifts 32 bits; m_last = 1 on the 4th word.
    - After the 4th beat:
      - if cfg_key_reuse && key_valid, go to LOAD_DATA;
      - otherwise clear key_valid and go to LOAD_KEY.
    - cfg_key_reuse is sampled only at that transition.
- Minimum core_start low time between jobs is ≥ 2 cycles. This is guaranteed because DRAIN lasts ≥ 4 cycles.
- The word counter is 2 bits and wraps 3→0 on the final beat of each phase.
- s_ready is 0 in START, BUSY and DRAIN; no input is buffered during encryption.
- err is cleared only by reset.
- A core_ready glitch to 1 in START is ignored; only the 1→0 then 0→1 sequence advances the FSM.
- Latency:
  - Last input beat → core_start high: 1 cycle.
  - core_ready rise → m_valid high: 1 cycle.

Decomposition:
- Shared package aes_pkg: the localparams WORDS_PER_BLOCK = 4 and the FSM state encoding ST_LOAD_KEY, ST_LOAD_DATA, ST_START, ST_BUSY, ST_DRAIN, plus an AES word-width constant.
- One natural sub-module: aes_word_ser, a 128→32 load/shift register with valid/ready and last generation, used for the DRAIN path.

Test Plan:
- FIPS-197 vector, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, fed as 8 words with the core attached → outputs 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a; m_last on the 4th word.
- Same key with cfg_key_reuse = 1, second pt fed as 4 words only → correct ciphertext; s_ready stays high for exactly 4 beats before START.
- m_ready held low for 5 cycles mid-DRAIN → m_data and m_last are unchanged, no word is lost, and the order is preserved.
- core_ready tied to 1 by a stub → err = 1 after TIMEOUT = 16 cycles in START, core_start = 0, key_valid = 0, FSM back to LOAD_KEY.
- rst_n pulsed low during BUSY → next edge: all outputs 0; a fresh 8-word job completes normally.
- s_valid toggling every other cycle during load → core_start rises exactly 1 cycle after the 8th accepted beat, with correct core_key and core_data.
